// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the
// load/store unit, with byte-lane write steering and load alignment/extension.
module mem_port_arbiter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [Width-1:0] i_addr,
    output logic             i_ack,
    output logic [Width-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [Width-1:0] d_addr,
    input  logic [Width-1:0] d_wdata,
    input  logic [1:0]       d_size,
    input  logic             d_unsigned,
    output logic             d_ack,
    output logic [Width-1:0] d_rdata,
    output logic             d_misaligned,
    output logic [Width-1:0] mem_addr_o,
    output logic             mem_re,
    output logic             mem_we,
    output logic [3:0]       mem_w_sel,
    output logic [Width-1:0] mem_data_o,
    input  logic [Width-1:0] mem_data_i,
    input  logic             mem_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_MISAL = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    logic [1:0]       state_q, state_d;
    logic             last_d_q, last_d_d;
    logic [Width-1:0] addr_q, addr_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             we_q, we_d;
    logic             unsigned_q, unsigned_d;

    logic             grant_d;
    logic             d_is_misal;
    logic [Width-1:0] shifted;
    logic [Width-1:0] load_fmt;

    // Data wins a tie unless it won the previous grant.
    assign grant_d    = d_req && (!i_req || !last_d_q);
    assign d_is_misal = ((d_size == SIZE_HALF) && d_addr[0]) ||
                        (d_size[1] && (d_addr[1:0] != 2'b00));

    // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        we_d       = we_q;
        unsigned_d = unsigned_q;
        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    size_d     = d_size;
                    we_d       = d_we;
                    unsigned_d = d_unsigned;
                    last_d_d   = 1'b1;
                    state_d    = d_is_misal ? S_MISAL : S_DATA;
                end else if (i_req) begin
                    addr_d     = i_addr;
                    wdata_d    = '0;
                    size_d     = 2'd2;
                    we_d       = 1'b0;
                    unsigned_d = 1'b0;
                    last_d_d   = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign shifted = mem_data_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            SIZE_BYTE: load_fmt = {{(Width-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_fmt = {{(Width-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
            default:   load_fmt = mem_data_i;
        endcase
    end

    always_comb begin
        i_ack        = 1'b0;
        i_rdata      = '0;
        d_ack        = 1'b0;
        d_rdata      = '0;
        d_misaligned = 1'b0;
        mem_addr_o   = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_w_sel    = 4'b0000;
        mem_data_o   = '0;
        case (state_q)
            S_FETCH: begin
                mem_addr_o = {addr_q[Width-1:2], 2'b00};
                mem_re     = 1'b1;
                mem_w_sel  = 4'b1111;
                if (mem_ack) begin
                    i_ack   = 1'b1;
                    i_rdata = mem_data_i;
                end
            end
            S_DATA: begin
                mem_addr_o = {addr_q[Width-1:2], 2'b00};
                mem_re     = ~we_q;
                mem_we     = we_q;
                mem_w_sel  = 4'b1111;
                if (we_q) begin
                    // Stores replicate the right-aligned data across every lane.
                    case (size_q)
                        SIZE_BYTE: begin
                            mem_w_sel  = 4'b0001 << addr_q[1:0];
                            mem_data_o = {(Width/8){wdata_q[7:0]}};
                        end
                        SIZE_HALF: begin
                            mem_w_sel  = 4'b0011 << addr_q[1:0];
                            mem_data_o = {(Width/16){wdata_q[15:0]}};
                        end
                        default: mem_data_o = wdata_q;
                    endcase
                end
                if (mem_ack) begin
                    d_ack   = 1'b1;
                    d_rdata = we_q ? '0 : load_fmt;
                end
            end
            S_MISAL: begin
                d_ack        = 1'b1;
                d_misaligned = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // NOTE: the latched request fields have no reset; they only reach outputs outside IDLE.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        size_q     <= size_d;
        we_q       <= we_d;
        unsigned_q <= unsigned_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, d_req, d_we, d_unsigned, d_ack, d_misaligned;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_re, mem_we, mem_ack;
    logic [3:0]  mem_w_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.Width(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_ack(d_ack),
        .d_rdata(d_rdata), .d_misaligned(d_misaligned),
        .mem_addr_o(mem_addr_o), .mem_re(mem_re), .mem_we(mem_we),
        .mem_w_sel(mem_w_sel), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic [3:0]  exp_sel;
        logic [31:0] exp_mdo;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_size = 0; d_unsigned = 0; mem_data_i = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, " ctrl"}, 32'({i_ack, d_ack, d_misaligned, mem_re, mem_we, mem_w_sel}), 32'd0);
        check({name, " addr"}, mem_addr_o, 32'd0);
        check({name, " mdo"}, mem_data_o, 32'd0);
        check({name, " rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    task automatic perturb();
        i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_size = 2'($urandom); d_unsigned = 1'($urandom);
    endtask

    // Reference model: expectations computed directly from the access rules.
    function automatic logic model_misal(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd1) return (off % 2) != 0;
        if (size >= 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_lanes(input logic we, input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (!we || size >= 2'd2) return 4'hF;
        if (size == 2'd0) return 4'(1 << off);
        return 4'(3 << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'd0) return (wdata % 256) * 32'h0101_0101;
        if (size == 2'd1) return (wdata % 65536) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] mdata);
        logic [31:0] s = mdata >> (8 * (addr % 4));
        logic [31:0] v;
        if (size == 2'd0) begin
            v = s % 256;
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = s % 65536;
            if (!uns && v >= 32768) v = v - 32'd65536;
        end else begin
            v = mdata;
        end
        return v;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v = vecs[idx];
        int lat = idx % 3;
        d_req = 1; d_we = v.we; d_addr = v.addr; d_size = v.size;
        d_unsigned = v.uns; d_wdata = v.wdata; mem_ack = 0;
        tick();
        // Inputs change after grant; the access must use the latched copy.
        d_req = 0; d_addr = 32'hFFFF_FFFF; d_size = v.size ^ 2'b01;
        d_we = ~v.we; d_wdata = ~v.wdata; d_unsigned = ~v.uns;
        if (v.exp_mis) begin
            @(negedge clk);
            check($sformatf("vec%0d mis ack", idx), 32'({d_ack, d_misaligned}), 32'd3);
            check($sformatf("vec%0d mis mem", idx), 32'({mem_re, mem_we, mem_w_sel}), 32'd0);
            check($sformatf("vec%0d mis rdata", idx), d_rdata, 32'd0);
            tick();
        end else begin
            for (int c = 0; c <= lat; c++) begin
                mem_ack = (c == lat);
                mem_data_i = (c == lat) ? v.mdata : 32'h5555_AAAA;
                @(negedge clk);
                check($sformatf("vec%0d re/we", idx), 32'({mem_re, mem_we}), 32'({~v.we, v.we}));
                check($sformatf("vec%0d sel", idx), 32'(mem_w_sel), 32'(v.exp_sel));
                check($sformatf("vec%0d addr", idx), mem_addr_o, v.addr & ~32'd3);
                if (v.we) check($sformatf("vec%0d mdo", idx), mem_data_o, v.exp_mdo);
                check($sformatf("vec%0d ack", idx), 32'({d_ack, d_misaligned, i_ack}), (c == lat) ? 32'd4 : 32'd0);
                check($sformatf("vec%0d rdata", idx), d_rdata, (c == lat) ? v.exp_rdata : 32'd0);
                tick();
            end
        end
        mem_ack = 0;
        @(negedge clk);
        check($sformatf("vec%0d idle after", idx), 32'({d_ack, mem_re, mem_we}), 32'd0);
    endtask

    initial begin
        logic last_d_m;
        clear_inputs();

        vecs[0]  = '{1'b1, 32'h202, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 4'b0100, 32'hA5A5_A5A5, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h102, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 32'h300, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h203, 2'd0, 1'b0, 32'h1234_5677, 32'h0, 4'b1000, 32'h7777_7777, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 32'h8001_1234, 4'b1111, 32'h0, 32'hFFFF_8001, 1'b0};
        vecs[5]  = '{1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 32'h8001_1234, 4'b1111, 32'h0, 32'h0000_8001, 1'b0};
        vecs[6]  = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 32'h8000_0000, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0};
        vecs[7]  = '{1'b0, 32'h101, 2'd0, 1'b1, 32'h0, 32'h0000_FF00, 4'b1111, 32'h0, 32'h0000_00FF, 1'b0};
        vecs[8]  = '{1'b0, 32'h400, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b0, 32'h500, 2'd3, 1'b0, 32'h0, 32'hA5A5_5A5A, 4'b1111, 32'h0, 32'hA5A5_5A5A, 1'b0};
        vecs[10] = '{1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h103, 2'd1, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 32'h102, 2'd3, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 32'h100, 2'd1, 1'b0, 32'h0, 32'h1234_7FFF, 4'b1111, 32'h0, 32'h0000_7FFF, 1'b0};

        // Reset state: outputs quiet even with a stray mem_ack.
        mem_ack = 1; mem_data_i = 32'h1357_9BDF;
        do_reset();
        @(negedge clk);
        check_quiet("reset");
        mem_ack = 0;

        // Fetch only, completing on the third access cycle.
        tick();
        i_req = 1; i_addr = 32'h1003;
        tick();
        for (int c = 0; c < 3; c++) begin
            mem_ack = (c == 2);
            mem_data_i = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
            if (c == 2) i_req = 0;
            @(negedge clk);
            check("fetch re/we", 32'({mem_re, mem_we}), 32'd2);
            check("fetch addr", mem_addr_o, 32'h1000);
            check("fetch sel", 32'(mem_w_sel), 32'hF);
            check("fetch i_ack", 32'({i_ack, d_ack}), (c == 2) ? 32'd2 : 32'd0);
            check("fetch i_rdata", i_rdata, (c == 2) ? 32'hDEAD_BEEF : 32'd0);
            tick();
        end
        @(negedge clk);
        check_quiet("fetch idle");
        mem_ack = 0;

        for (int i = 0; i < 14; i++) run_vec(i);

        // Contention: both requesters held from reset, alternate grants.
        clear_inputs();
        i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h40; d_size = 2'd2;
        mem_ack = 1; mem_data_i = 32'h1111_2222;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("contend d_ack k%0d", k), 32'(d_ack), 32'(k % 4 == 1));
            check($sformatf("contend i_ack k%0d", k), 32'(i_ack), 32'(k % 4 == 3));
            if (k % 2 == 0) check_quiet($sformatf("contend gap k%0d", k));
            tick();
        end

        // Reset mid-fetch: abandoned, later mem_ack ignored.
        clear_inputs();
        do_reset();
        i_req = 1; i_addr = 32'h2000;
        tick();
        @(negedge clk);
        check("rstmid re", 32'(mem_re), 32'd1);
        tick();
        rst = 1; i_req = 0;
        tick();
        rst = 0; mem_ack = 1; mem_data_i = 32'hFEED_FACE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_quiet($sformatf("rstmid after%0d", k));
            tick();
        end

        // Randomized traffic against the model.
        clear_inputs();
        do_reset();
        last_d_m = 1'b0;
        for (int t = 0; t < 300; t++) begin
            logic ir, dr, win_d, misal, fwe, funs;
            logic [31:0] faddr, fwdata, mdata;
            logic [1:0] fsize;
            int lat;
            perturb();
            mem_ack = 1'($urandom); mem_data_i = $urandom;
            ir = i_req; dr = d_req;
            faddr = dr ? d_addr : i_addr; fsize = d_size; fwe = d_we;
            fwdata = d_wdata; funs = d_unsigned;
            @(negedge clk);
            check_quiet("rand idle");
            tick();
            if (!ir && !dr) continue;
            win_d = dr && (!ir || !last_d_m);
            last_d_m = win_d;
            if (!win_d) begin
                faddr = i_addr; fwe = 1'b0; fsize = 2'd2;
            end
            misal = win_d && model_misal(fsize, faddr);
            perturb();
            if (misal) begin
                @(negedge clk);
                check("rand mis ack", 32'({d_ack, d_misaligned, i_ack}), 32'd6);
                check("rand mis mem", 32'({mem_re, mem_we, mem_w_sel}), 32'd0);
                check("rand mis rdata", d_rdata | i_rdata, 32'd0);
                tick();
                continue;
            end
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                mdata = $urandom;
                mem_ack = (c == lat); mem_data_i = mdata;
                @(negedge clk);
                check("rand re/we", 32'({mem_re, mem_we}), 32'({~fwe, fwe}));
                check("rand addr", mem_addr_o, faddr & ~32'd3);
                check("rand sel", 32'(mem_w_sel), 32'(model_lanes(fwe, fsize, faddr)));
                if (fwe) check("rand mdo", mem_data_o, model_wdata(fsize, fwdata));
                check("rand acks", 32'({i_ack, d_ack, d_misaligned}),
                      32'({(c == lat) && !win_d, (c == lat) && win_d, 1'b0}));
                check("rand i_rdata", i_rdata, ((c == lat) && !win_d) ? mdata : 32'd0);
                check("rand d_rdata", d_rdata,
                      ((c == lat) && win_d && !fwe) ? model_load(fsize, funs, faddr, mdata) : 32'd0);
                tick();
                perturb();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
